// File: rtl/led_animator.sv
// Parametrised LED pattern sequencer: bounce, rotate left/right and fill/drain bar.
// Optional comet trail in the one-hot modes is enabled by defining LED_ANIM_TRAIL_EN.
module led_animator #(
    parameter int WIDTH    = 18,
    parameter int STEP_DIV = 2777778
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] leds,
    output logic             dir,
    output logic             step
);

    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(STEP_DIV - 1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'b00,
        MODE_ROL    = 2'b01,
        MODE_ROR    = 2'b10,
        MODE_BAR    = 2'b11
    } mode_t;

    mode_t            mode_sel;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] next_head;
    logic             next_dir;
    logic             nd;
    logic             tick;
    logic             one_hot;
    logic             bar_ok;
    logic             norm;

    assign mode_sel = mode_t'(mode);
    assign tick     = en && (cnt == CNT_LAST);

    always_comb begin
        one_hot   = (head != '0) && ((head & (head - ONE)) == '0);
        // An all-ones bar wraps to zero on +1, so it counts as a valid bar.
        bar_ok    = (head != '0) && ((head & (head + ONE)) == '0);
        norm      = (mode_sel == MODE_BAR) ? !bar_ok : !one_hot;
        next_head = head;
        next_dir  = dir;
        nd        = dir;
        if (norm) begin
            next_head = ONE;
            next_dir  = 1'b0;
        end else begin
            case (mode_sel)
                MODE_BOUNCE: begin
                    nd        = (head == ONE) ? 1'b0 : (head[WIDTH-1] ? 1'b1 : dir);
                    next_head = nd ? (head >> 1) : (head << 1);
                    next_dir  = nd;
                end
                MODE_ROL: begin
                    next_head = {head[WIDTH-2:0], head[WIDTH-1]};
                    next_dir  = 1'b0;
                end
                MODE_ROR: begin
                    next_head = {head[0], head[WIDTH-1:1]};
                    next_dir  = 1'b1;
                end
                MODE_BAR: begin
                    nd        = (head == ONE) ? 1'b0 : ((&head) ? 1'b1 : dir);
                    next_head = nd ? (head >> 1) : {head[WIDTH-2:0], 1'b1};
                    next_dir  = nd;
                end
                default: begin
                    next_head = ONE;
                    next_dir  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            cnt  <= '0;
            head <= ONE;
            dir  <= 1'b0;
            step <= 1'b0;
        end else begin
            step <= tick;
            if (en) begin
                cnt <= tick ? '0 : cnt + 1'b1;
            end
            if (tick) begin
                head <= next_head;
                dir  <= next_dir;
            end
        end
    end

`ifdef LED_ANIM_TRAIL_EN
    logic [WIDTH-1:0] trail;
    logic [WIDTH-1:0] next_trail;
    logic [WIDTH-1:0] leds_r;

    assign next_trail = norm ? '0 : head;

    // The displayed composition follows the mode latched at the tick, so a
    // mode change between ticks cannot disturb the LEDs.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            trail  <= '0;
            leds_r <= ONE;
        end else if (tick) begin
            trail  <= next_trail;
            leds_r <= (mode_sel == MODE_BAR) ? next_head : (next_head | next_trail);
        end
    end

    assign leds = leds_r;
`else
    assign leds = head;
`endif

endmodule

// File: tb/tb_led_animator.sv
// Scoreboard bench for led_animator: WIDTH=4 with STEP_DIV=1 and STEP_DIV=3 instances.
// Expected patterns follow the trail variant when LED_ANIM_TRAIL_EN is defined.
module tb_led_animator;

`ifdef LED_ANIM_TRAIL_EN
    localparam bit TRAIL = 1'b1;
`else
    localparam bit TRAIL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       en_a = 1'b1;
    logic       en_b = 1'b1;
    logic [1:0] mode_a = 2'b00;
    logic [1:0] mode_b = 2'b00;
    logic [3:0] leds_a, leds_b;
    logic       dir_a, dir_b, step_a, step_b;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        bit         sel;
        logic [3:0] leds;
        logic       dir;
        logic       step;
    } exp_t;

    exp_t sb[$];

    led_animator #(.WIDTH(4), .STEP_DIV(1)) u_fast (
        .clk(clk), .res(res), .en(en_a), .mode(mode_a),
        .leds(leds_a), .dir(dir_a), .step(step_a)
    );

    led_animator #(.WIDTH(4), .STEP_DIV(3)) u_div (
        .clk(clk), .res(res), .en(en_b), .mode(mode_b),
        .leds(leds_b), .dir(dir_b), .step(step_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input bit sel, input logic [3:0] l,
                        input logic d, input logic s);
        exp_t e;
        e.tag = tag; e.sel = sel; e.leds = l; e.dir = d; e.step = s;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            if (!e.sel) begin
                check({e.tag, "_leds"}, 32'(leds_a), 32'(e.leds));
                check({e.tag, "_dir"},  32'(dir_a),  32'(e.dir));
                check({e.tag, "_step"}, 32'(step_a), 32'(e.step));
            end else begin
                check({e.tag, "_leds"}, 32'(leds_b), 32'(e.leds));
                check({e.tag, "_dir"},  32'(dir_b),  32'(e.dir));
                check({e.tag, "_step"}, 32'(step_b), 32'(e.step));
            end
        end
    endtask

    task automatic drain();
        int n;
        n = sb.size();
        for (int i = 0; i < n; i++) pop_check();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        res = 1'b1;
        #1;
        check("rst_leds_a", 32'(leds_a), 32'd1);
        check("rst_dir_a",  32'(dir_a),  32'd0);
        check("rst_step_a", 32'(step_a), 32'd0);
        check("rst_leds_b", 32'(leds_b), 32'd1);
        @(posedge clk);
        #1;
        res = 1'b0;
    endtask

    logic [3:0] seq[8];
    logic       dseq[8];

    initial begin
        // Bounce
        mode_a = 2'b00;
        do_reset();
        if (TRAIL) seq = '{4'b0011, 4'b0110, 4'b1100, 4'b1100, 4'b0110, 4'b0011, 4'b0011, 4'b0110};
        else       seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};
        dseq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) push($sformatf("bounce%0d", i), 1'b0, seq[i], dseq[i], 1'b1);
        drain();

        // Rotate left
        mode_a = 2'b01;
        do_reset();
        if (TRAIL) seq = '{4'b0011, 4'b0110, 4'b1100, 4'b1001, 4'b0011, 4'b0, 4'b0, 4'b0};
        else       seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0, 4'b0, 4'b0};
        for (int i = 0; i < 5; i++) push($sformatf("rol%0d", i), 1'b0, seq[i], 1'b0, 1'b1);
        drain();

        // Rotate right
        mode_a = 2'b10;
        do_reset();
        if (TRAIL) seq = '{4'b1001, 4'b1100, 4'b0110, 4'b0011, 4'b1001, 4'b0, 4'b0, 4'b0};
        else       seq = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0, 4'b0, 4'b0};
        for (int i = 0; i < 5; i++) push($sformatf("ror%0d", i), 1'b0, seq[i], 1'b1, 1'b1);
        drain();

        // Fill/drain bar
        mode_a = 2'b11;
        do_reset();
        seq  = '{4'b0011, 4'b0111, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0011, 4'b0111};
        dseq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) push($sformatf("bar%0d", i), 1'b0, seq[i], dseq[i], 1'b1);
        drain();

        // Bar to bounce: normalising tick, then a normal bounce step
        mode_a = 2'b11;
        do_reset();
        push("bar_a", 1'b0, 4'b0011, 1'b0, 1'b1);
        push("bar_b", 1'b0, 4'b0111, 1'b0, 1'b1);
        drain();
        mode_a = 2'b00;
        push("norm", 1'b0, 4'b0001, 1'b0, 1'b1);
        push("post_norm", 1'b0, TRAIL ? 4'b0011 : 4'b0010, 1'b0, 1'b1);
        drain();

        // Async reset between edges
        @(posedge clk);
        #3;
        res = 1'b1;
        #1;
        check("async_rst_leds", 32'(leds_a), 32'd1);
        check("async_rst_step", 32'(step_a), 32'd0);
        check("async_rst_dir",  32'(dir_a),  32'd0);
        #2;
        res = 1'b0;

        // Prescaler with freeze
        mode_b = 2'b00;
        en_b   = 1'b1;
        do_reset();
        push("div0", 1'b1, 4'b0001, 1'b0, 1'b0);
        push("div1", 1'b1, 4'b0001, 1'b0, 1'b0);
        push("div2", 1'b1, TRAIL ? 4'b0011 : 4'b0010, 1'b0, 1'b1);
        push("div3", 1'b1, TRAIL ? 4'b0011 : 4'b0010, 1'b0, 1'b0);
        drain();
        en_b = 1'b0;
        for (int i = 0; i < 5; i++)
            push($sformatf("frz%0d", i), 1'b1, TRAIL ? 4'b0011 : 4'b0010, 1'b0, 1'b0);
        drain();
        en_b = 1'b1;
        push("resume0", 1'b1, TRAIL ? 4'b0011 : 4'b0010, 1'b0, 1'b0);
        push("resume1", 1'b1, TRAIL ? 4'b0110 : 4'b0100, 1'b0, 1'b1);
        push("resume2", 1'b1, TRAIL ? 4'b0110 : 4'b0100, 1'b0, 1'b0);
        push("resume3", 1'b1, TRAIL ? 4'b0110 : 4'b0100, 1'b0, 1'b0);
        push("resume4", 1'b1, TRAIL ? 4'b1100 : 4'b1000, 1'b0, 1'b1);
        drain();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
